// File: rtl/pong_game_sequencer.sv
// Game-flow controller for the Pong datapath: game state, lives, BCD score, speed level and step enables.
// Optional speed ramp is built when the SPEED_RAMP_EN macro is defined; otherwise speed stays 0.
module pong_game_sequencer #(
    parameter int unsigned TICK_DIV       = 833333,
    parameter int unsigned SERVE_TICKS    = 120,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned SPEED_STEP_PTS = 5,
    parameter int unsigned MAX_SPEED      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       hit_in,
    input  logic       lose_in,
    output logic       ball_step,
    output logic       paddle_step,
    output logic       ball_serve,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic [2:0] speed,
    output logic [2:0] state,
    output logic       game_over
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SERVE_TICKS + 1);

    if (TICK_DIV < 2 || SERVE_TICKS < 1 || LIVES < 1 || LIVES > 7 ||
        SPEED_STEP_PTS < 1 || MAX_SPEED > 7) begin : g_bad_cfg
        $error("pong_game_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_MISS  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [TW-1:0] tick_cnt;
    logic          game_tick_c;

    logic          start_prev;
    logic          pause_prev;
    logic          edge_armed;
    logic          start_edge_c;
    logic          pause_edge_c;

    logic [SW-1:0] serve_cnt;
    logic [SW-1:0] serve_cnt_d;
    logic [7:0]    score_d;
    logic [2:0]    lives_d;
    logic [2:0]    speed_d;
    logic          ball_step_d;
    logic          paddle_step_d;
    logic          ball_serve_d;
    logic          game_over_d;

    logic          new_game_c;
    logic          hit_ok_c;
    logic          lose_ok_c;

    // Free-running frame-rate divider
    assign game_tick_c = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (game_tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Button edge detect; disarmed for the first cycle out of reset so a held level is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_prev <= 1'b0;
            pause_prev <= 1'b0;
            edge_armed <= 1'b0;
        end else begin
            start_prev <= start_btn;
            pause_prev <= pause_btn;
            edge_armed <= 1'b1;
        end
    end

    assign start_edge_c = edge_armed & start_btn & ~start_prev;
    assign pause_edge_c = edge_armed & pause_btn & ~pause_prev;

    assign new_game_c = start_edge_c && (state_q == S_IDLE || state_q == S_OVER);
    assign lose_ok_c  = lose_in && (state_q == S_PLAY);
    assign hit_ok_c   = hit_in && !lose_in && (state_q == S_PLAY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge_c) state_d = S_SERVE;
            end
            S_SERVE: begin
                if (game_tick_c && serve_cnt == SW'(1)) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (lose_in)           state_d = S_MISS;
                else if (pause_edge_c) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (start_edge_c)      state_d = S_IDLE;
                else if (pause_edge_c) state_d = S_PLAY;
            end
            S_MISS: begin
                state_d = (lives == 3'd0) ? S_OVER : S_SERVE;
            end
            S_OVER: begin
                if (start_edge_c) state_d = S_SERVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating two-digit BCD increment
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        ball_step_d   = game_tick_c && (state_q == S_PLAY);
        paddle_step_d = game_tick_c && (state_q == S_SERVE || state_q == S_PLAY);
        ball_serve_d  = !(state_d == S_PLAY || state_d == S_PAUSE);
        game_over_d   = (state_d == S_OVER);
        score_d       = score;
        lives_d       = lives;
        serve_cnt_d   = serve_cnt;

        if (new_game_c) begin
            score_d     = 8'h00;
            lives_d     = 3'(LIVES);
            serve_cnt_d = SW'(SERVE_TICKS);
        end

        if (state_q == S_SERVE && game_tick_c && serve_cnt != SW'(1)) begin
            serve_cnt_d = serve_cnt - SW'(1);
        end

        if (state_q == S_MISS && lives != 3'd0) begin
            serve_cnt_d = SW'(SERVE_TICKS);
        end

        if (lose_ok_c && lives != 3'd0) begin
            lives_d = lives - 3'd1;
        end

        if (hit_ok_c) begin
            score_d = bcd_inc(score);
        end
    end

`ifdef SPEED_RAMP_EN
    localparam int unsigned PW = $clog2(SPEED_STEP_PTS + 1);

    logic [PW-1:0] pts;
    logic [PW-1:0] pts_d;

    // Every SPEED_STEP_PTS hits bump the speed level, saturating at MAX_SPEED
    always_comb begin
        pts_d   = pts;
        speed_d = speed;
        if (new_game_c) begin
            pts_d   = '0;
            speed_d = 3'd0;
        end else if (hit_ok_c) begin
            if (pts + PW'(1) == PW'(SPEED_STEP_PTS)) begin
                pts_d = '0;
                if (speed < 3'(MAX_SPEED)) speed_d = speed + 3'd1;
            end else begin
                pts_d = pts + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pts <= '0;
        end else begin
            pts <= pts_d;
        end
    end
`else
    assign speed_d = 3'd0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            serve_cnt   <= '0;
            score       <= 8'h00;
            lives       <= 3'(LIVES);
            speed       <= 3'd0;
            ball_step   <= 1'b0;
            paddle_step <= 1'b0;
            ball_serve  <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            serve_cnt   <= serve_cnt_d;
            score       <= score_d;
            lives       <= lives_d;
            speed       <= speed_d;
            ball_step   <= ball_step_d;
            paddle_step <= paddle_step_d;
            ball_serve  <= ball_serve_d;
            game_over   <= game_over_d;
        end
    end

    assign state = state_q;

endmodule
